meas_sequencer: RTL and testbench

- Top-level measurement controller for the inclinometer frequency-counting path.
- Sequences one frame: clear counters, open the gate window for a fixed number of read_clk cycles, wait for the counters to report done, then snapshot f0/fx.
- Streams the 64-bit snapshot as eight 11-bit {index, byte} words over a valid/ack handshake to the host interface.
- Replaces the free-running ready-driven readout with a single clocked, timeout-protected sequence.

---
 rtl/meas_seq_pkg.sv | 24 ++
 rtl/meas_sequencer_frame_serializer.sv | 74 +++++++
 rtl/meas_sequencer.sv | 138 +++++++++++++
 tb/tb_meas_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_seq_pkg.sv
// Shared types and constants for the measurement sequencer slice.
package meas_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_GATE,
    ST_WAIT,
    ST_SEND
  } state_t;

  localparam int WORD_W    = 11;
  localparam int IDX_W     = 3;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 8;
  localparam int SNAP_W    = BYTE_W * NUM_BYTES;

  // Byte idx of the snapshot; byte 0 is the least significant byte.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [SNAP_W-1:0] data,
                                                 input logic [IDX_W-1:0]  idx);
    return data[int'(idx)*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/meas_sequencer_frame_serializer.sv
// Holds the frozen 64-bit snapshot and streams it as eight {idx, byte} words
// over a valid/ack handshake. load_i starts a stream, abort_i kills it.
module frame_serializer
  import meas_seq_pkg::*;
(
  input  logic              read_clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic [SNAP_W-1:0] snap_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  output logic              last_xfer_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [SNAP_W-1:0] data_q;
  logic [SNAP_W-1:0] data_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              valid_q;
  logic              valid_d;
  logic              xfer;

  assign xfer        = valid_q & ack_i;
  assign last_xfer_o = xfer & (idx_q == LAST_IDX);

  // Next-state for buffer, index and valid; abort has priority over everything.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (abort_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (load_i) begin
      data_d  = snap_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      // idx never wraps: the last word ends the stream instead.
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Word is forced to zero whenever it is not being offered.
  always_comb begin
    valid_o = valid_q;
    word_o  = '0;
    if (valid_q) begin
      word_o = {idx_q, byte_sel(data_q, idx_q)};
    end
  end

endmodule

// File: rtl/meas_sequencer.sv
// Frame controller for the frequency-counting path: clear counters, open the
// gate for GATE_CYCLES, wait (bounded) for cnt_done, snapshot and stream out.
module meas_sequencer
  import meas_seq_pkg::*;
#(
  parameter int GATE_CYCLES    = 50000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              read_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic              cnt_done,
  input  logic [31:0]       f0_num,
  input  logic [31:0]       fx_num,
  input  logic              out_ack,
  output logic              cnt_clr,
  output logic              gate_en,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;
  logic             done_q;
  logic             cnt_zero;
  logic             snap_load;
  logic             timeout_hit;
  logic             last_xfer;

  assign cnt_zero    = (cnt_q == '0);
  assign snap_load   = (state_q == ST_WAIT) & cnt_done & ~abort;
  assign timeout_hit = (state_q == ST_WAIT) & ~cnt_done & cnt_zero;

  // State register.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR:  state_d = ST_GATE;
      ST_GATE: if (cnt_zero) state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_done) begin
          state_d = ST_SEND;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: if (last_xfer) state_d = continuous ? ST_CLR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  // Moore outputs decoded from the state; all drop to 0 in IDLE.
  always_comb begin
    cnt_clr = (state_q == ST_CLR);
    gate_en = (state_q == ST_GATE);
    busy    = (state_q != ST_IDLE);
  end

  // Shared down-counter: gate length in GATE, timeout budget in WAIT.
  always_comb begin
    cnt_d = '0;
    if (!abort) begin
      case (state_q)
        ST_CLR:  cnt_d = GATE_LOAD;
        ST_GATE: cnt_d = cnt_zero ? TO_LOAD : cnt_q - 1'b1;
        ST_WAIT: cnt_d = cnt_zero ? '0 : cnt_q - 1'b1;
        default: cnt_d = '0;
      endcase
    end
  end

  // Sticky timeout flag: survives abort, cleared only by an accepted start.
  always_comb begin
    err_d = err_q;
    if (!abort) begin
      if ((state_q == ST_IDLE) && start) begin
        err_d = 1'b0;
      end else if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
  end

  // Counter, error flag and frame_done pulse registers.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      done_q <= last_xfer & ~abort;
    end
  end

  assign err_timeout = err_q;
  assign frame_done  = done_q;

  frame_serializer u_ser (
    .read_clk    (read_clk),
    .rst_n       (rst_n),
    .load_i      (snap_load),
    .abort_i     (abort),
    .ack_i       (out_ack),
    .snap_i      ({fx_num, f0_num}),
    .word_o      (out_word),
    .valid_o     (out_valid),
    .last_xfer_o (last_xfer)
  );

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer with a short gate and timeout.
module tb_meas_sequencer;

  localparam int GATE = 8;
  localparam int TOUT = 16;

  logic        read_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        continuous;
  logic        cnt_done;
  logic [31:0] f0_num;
  logic [31:0] fx_num;
  logic        out_ack;
  logic        cnt_clr;
  logic        gate_en;
  logic [10:0] out_word;
  logic        out_valid;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] nom_words [8];

  meas_sequencer #(
    .GATE_CYCLES    (GATE),
    .TIMEOUT_CYCLES (TOUT),
    .CNT_W          (16)
  ) dut (
    .read_clk    (read_clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .continuous  (continuous),
    .cnt_done    (cnt_done),
    .f0_num      (f0_num),
    .fx_num      (fx_num),
    .out_ack     (out_ack),
    .cnt_clr     (cnt_clr),
    .gate_en     (gate_en),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  always #5 read_clk = ~read_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [10:0] exp_word(input logic [31:0] f0, input logic [31:0] fx, input int i);
    logic [31:0] src;
    logic [7:0]  b;
    src = (i < 4) ? f0 : fx;
    b   = 8'(src >> (8 * (i % 4)));
    return {3'(i), b};
  endfunction

  // Entered at the negedge of a CLR cycle; returns at the negedge of the first SEND cycle.
  task automatic gate_wait(input int wait_n);
    check_val("clr_pulse", cnt_clr, 1);
    check_val("clr_gate_low", gate_en, 0);
    check_val("clr_busy", busy, 1);
    @(negedge read_clk);
    for (int g = 0; g < GATE; g++) begin
      check_val("gate_on", gate_en, 1);
      check_val("gate_clr_low", cnt_clr, 0);
      @(negedge read_clk);
    end
    check_val("gate_closed", gate_en, 0);
    check_val("wait_no_valid", out_valid, 0);
    for (int w = 1; w < wait_n; w++) @(negedge read_clk);
    cnt_done = 1'b1;
    @(negedge read_clk);
    cnt_done = 1'b0;
  endtask

  // Streams the eight words; optional stall at one index and mid-stream input change.
  task automatic drain(input logic [31:0] f0, input logic [31:0] fx, input bit use_table,
                       input int stall_idx, input int stall_len, input bit chg);
    logic [10:0] expw;
    for (int i = 0; i < 8; i++) begin
      expw = use_table ? nom_words[i] : exp_word(f0, fx, i);
      if (i == stall_idx) begin
        out_ack = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_val("hold_valid", out_valid, 1);
          check_val("hold_word", out_word, expw);
          @(negedge read_clk);
        end
      end
      out_ack = 1'b1;
      check_val("word_valid", out_valid, 1);
      check_val("word", out_word, expw);
      if (chg && i == 1) begin
        f0_num = 32'hFFFF_FFFF;
        fx_num = 32'hFFFF_FFFF;
      end
      @(negedge read_clk);
    end
    check_val("frame_done", frame_done, 1);
    check_val("post_valid", out_valid, 0);
    check_val("post_word", out_word, 0);
  endtask

  initial begin
    nom_words[0] = 11'h078; nom_words[1] = 11'h156;
    nom_words[2] = 11'h234; nom_words[3] = 11'h312;
    nom_words[4] = 11'h409; nom_words[5] = 11'h5EF;
    nom_words[6] = 11'h6CD; nom_words[7] = 11'h7AB;

    rst_n = 1'b0; start = 0; abort = 0; continuous = 0; cnt_done = 0; out_ack = 0;
    f0_num = 32'h1234_5678; fx_num = 32'hABCD_EF09;
    @(negedge read_clk);
    @(negedge read_clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_word", out_word, 0);
    check_val("rst_gate", gate_en, 0);
    check_val("rst_clr", cnt_clr, 0);
    check_val("rst_err", err_timeout, 0);
    check_val("rst_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge read_clk);
    check_val("idle_busy", busy, 0);

    // 1: nominal frame
    start = 1'b1; out_ack = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    gate_wait(3);
    drain(32'h1234_5678, 32'hABCD_EF09, 1'b1, 8, 0, 1'b0);
    check_val("nom_idle", busy, 0);
    @(negedge read_clk);
    check_val("done_pulse_end", frame_done, 0);

    // 2: backpressure at idx 2
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    gate_wait(2);
    drain(32'h1234_5678, 32'hABCD_EF09, 1'b1, 2, 5, 1'b0);
    check_val("bp_idle", busy, 0);
    @(negedge read_clk);

    // 3: timeout
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    check_val("to_clr", cnt_clr, 1);
    @(negedge read_clk);
    for (int g = 0; g < GATE; g++) @(negedge read_clk);
    for (int c = 0; c < TOUT; c++) begin
      check_val("to_err_low", err_timeout, 0);
      check_val("to_no_valid", out_valid, 0);
      check_val("to_busy", busy, 1);
      @(negedge read_clk);
    end
    check_val("to_err_set", err_timeout, 1);
    check_val("to_idle", busy, 0);
    check_val("to_valid", out_valid, 0);
    abort = 1'b1;
    @(negedge read_clk);
    abort = 1'b0;
    check_val("err_kept_abort", err_timeout, 1);

    // 4: next start clears error; snapshot stays frozen during SEND
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    check_val("err_cleared", err_timeout, 0);
    gate_wait(3);
    drain(32'h1234_5678, 32'hABCD_EF09, 1'b1, 8, 0, 1'b1);
    @(negedge read_clk);
    f0_num = 32'h1234_5678; fx_num = 32'hABCD_EF09;

    // 5a: abort together with start at idx 3
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    gate_wait(1);
    out_ack = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge read_clk);
    check_val("ab_word3", out_word, 11'h312);
    abort = 1'b1; start = 1'b1;
    @(negedge read_clk);
    abort = 1'b0; start = 1'b0;
    check_val("ab_valid", out_valid, 0);
    check_val("ab_word", out_word, 0);
    check_val("ab_busy", busy, 0);
    check_val("ab_done", frame_done, 0);
    @(negedge read_clk);
    check_val("ab_start_ignored", busy, 0);
    check_val("ab_no_clr", cnt_clr, 0);

    // 5b: async reset mid-gate
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    @(negedge read_clk);
    @(negedge read_clk);
    check_val("pre_rst_gate", gate_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_gate", gate_en, 0);
    check_val("async_busy", busy, 0);
    @(negedge read_clk);
    rst_n = 1'b1;
    @(negedge read_clk);
    check_val("post_rst_idle", busy, 0);

    // 6: continuous mode, two frames
    continuous = 1'b1;
    start = 1'b1;
    @(negedge read_clk);
    start = 1'b0;
    gate_wait(3);
    drain(32'h1234_5678, 32'hABCD_EF09, 1'b1, 8, 0, 1'b0);
    check_val("cont_busy", busy, 1);
    continuous = 1'b0;
    f0_num = 32'h0BAD_F00D; fx_num = 32'hC0DE_1234;
    gate_wait(2);
    drain(32'h0BAD_F00D, 32'hC0DE_1234, 1'b0, 8, 0, 1'b0);
    check_val("cont_end_idle", busy, 0);
    @(negedge read_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
